hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard, forwarding and multi-cycle-unit scoreboard for the RISC-V pipeline controller. It replaces the combinational forwarding and hazard pair with a block that tracks every issued instruction itself through FWD_STAGES downstream stages. It generates forwarding selects, load-use and RAW stalls, and flush handling. It also owns a busy scoreboard for one fixed-latency multi-cycle unit (mul/div). It sits beside the decode controller and is driven from the ID stage.

## Interface
- REG_AW, 5, register address width; x0 is never a hazard source.
- FWD_STAGES, 2, number of tracked downstream stages: stage 1 = EX, stage 2 = MEM, and so on. Legal range is 1..6.
- MC_LAT, 4, multi-cycle unit latency in cycles. Must be ≥ 2.
- SW, derived, equal to clog2(FWD_STAGES+1). Width of the forwarding selects.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_use_rs1, id_use_rs2  in  1  the source is actually read.
- id_rd  in  REG_AW  destination register.
- id_reg_we  in  1  the instruction writes id_rd.
- id_is_load  in  1  the instruction is a load.
- id_is_mc  in  1  the instruction is a multi-cycle-unit op.
- flush  in  1  branch/jump resolved taken in EX; kill the ID instruction.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  insert a NOP into ID/EX.
- fwd_a_sel, fwd_b_sel  out  SW  0 = register file; k = stage k result.
- mc_busy  out  1  multi-cycle unit occupied.
- mc_wb  out  1  one-cycle pulse: multi-cycle result is written this cycle on the dedicated register-file port.
- mc_wb_rd  out  REG_AW  destination register for mc_wb.

## Operation
- Tracking table: FWD_STAGES entries, each holding {valid, rd, we, load}. The table shifts one stage every cycle and never back-pressures.
- Stage 1 receives the ID instruction when it is accepted; otherwise it receives a bubble (valid=0).
- Acceptance condition: id_valid & !stall & !flush & !id_is_mc. Multi-cycle ops never enter the table.
- Match condition, per source: use & rs≠0 & entry.valid & entry.we & entry.rd==rs.
- Forward select is the lowest-index matching stage; if none matches, the select is 0.
- Load-use: a match in stage 1 whose entry has load=1 raises stall for one cycle. The load advances to stage 2 and then forwards.
- The multi-cycle scoreboard has two states.
  - IDLE → BUSY when an id_is_mc instruction is accepted (id_valid & !stall & !flush). This loads the counter with MC_LAT-1 and latches mc_rd.
  - BUSY: the counter decrements each cycle. When count==0, mc_wb=1, and the next edge returns to IDLE.
- Stall sources while in BUSY:
  - an ID source equal to mc_rd (RAW);
  - id_reg_we with id_rd==mc_rd (WAW);
  - id_is_mc (structural).
- flush has priority over stall: flush forces stall=0 and bubble=1. flush does not cancel an in-flight multi-cycle op, because that op is older.
- bubble = stall | flush.
- Reset mid-operation: all table entries become invalid, the scoreboard returns to IDLE, and no mc_wb is emitted.
- Reset values: stall=0, bubble=0, fwd_a_sel=0, fwd_b_sel=0, mc_busy=0, mc_wb=0, mc_wb_rd=0.

## Timing
- stall, bubble, fwd_*_sel and mc_wb are combinational from the registered table and scoreboard plus the current ID inputs. There is no added latency.
- Multi-cycle op accepted at edge t:
  - mc_busy=1 during cycles t+1 .. t+MC_LAT;
  - mc_wb pulses in cycle t+MC_LAT;
  - mc_busy=0 from t+MC_LAT+1.
- A dependent instruction stalls through the mc_wb cycle and issues at t+MC_LAT+1, reading the updated register file.
- Load-use costs exactly 1 stall cycle. The following cycle selects fwd=2.

## Configuration
- HZD_FORWARD_EN defined: forwarding operates as described above.
- HZD_FORWARD_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0;
  - any match in any stage 1..FWD_STAGES raises stall;
  - the multi-cycle behaviour is unchanged.

## Test plan
- Reset sequence: hold rst_n=0 for 2 cycles with id_valid=1 → all outputs 0. Release rst_n → the table is empty.
- ALU back-to-back: "add x5" then "sub x6,x5,x1" → fwd_a_sel=1, stall=0. One instruction later, x5 used again → fwd=2. Also repeat with rs=x0 and rd=x0 → fwd=0 in both cases.
- Load-use: "lw x7" then "add x8,x7,x7" → stall=1 and bubble=1 for 1 cycle, then fwd_a_sel=fwd_b_sel=2. With HZD_FORWARD_EN undefined → 2 stall cycles, fwd=0.
- Multi-cycle with MC_LAT=4: "mul x9" accepted at t, followed by "add x10,x9,x1" → stall for cycles t+1..t+4. mc_wb=1 with mc_wb_rd=9 only at t+4; add issues at t+5. A second mul during BUSY stalls, and so does an ID write to x9.
- Flush: flush=1 while ID holds "add x11" and a stall condition is present → stall=0, bubble=1, and x11 never appears as a forwarding source afterwards.
- Reset mid-BUSY: rst_n=0 at t+2 of an mc op → mc_busy=0 and no mc_wb pulse; an x9-dependent instruction issues without stall.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: the instruction descriptor from decode, and the
// stall/bubble/forwarding/multi-cycle controls returned by hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int SW     = 2
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_we;
  logic              id_is_load;
  logic              id_is_mc;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic [SW-1:0]     fwd_a_sel;
  logic [SW-1:0]     fwd_b_sel;
  logic              mc_busy;
  logic              mc_wb;
  logic [REG_AW-1:0] mc_wb_rd;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_we, id_is_load, id_is_mc, flush,
    input  stall, bubble, fwd_a_sel, fwd_b_sel, mc_busy, mc_wb, mc_wb_rd
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_we, id_is_load, id_is_mc, flush,
    output stall, bubble, fwd_a_sel, fwd_b_sel, mc_busy, mc_wb, mc_wb_rd
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and multi-cycle-unit scoreboard driven from the ID stage.
// Define HZD_FORWARD_EN to enable forwarding; otherwise every table hit stalls.
//
// state  | meaning
// S_IDLE | multi-cycle unit free
// S_BUSY | multi-cycle op in flight; count reaches 0 in its write-back cycle
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int MC_LAT     = 4
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave hz
);

  localparam int SW = $clog2(FWD_STAGES + 1);
  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  typedef enum logic {S_IDLE, S_BUSY} mc_state_t;

  // Index k of the table holds pipeline stage k+1.
  logic [FWD_STAGES-1:0]             tbl_valid;
  logic [FWD_STAGES-1:0]             tbl_we;
  logic [FWD_STAGES-1:0]             tbl_load;
  logic [FWD_STAGES-1:0][REG_AW-1:0] tbl_rd;

  mc_state_t         state, state_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [REG_AW-1:0] mc_rd, mc_rd_nxt;
  logic              mc_done;

  logic [FWD_STAGES-1:0] match_a, match_b;
  logic [SW-1:0]         sel_a, sel_b;
  logic                  load_use, tbl_stall, mc_stall, hz_stall, stall_int;
  logic                  accept_any, accept, mc_start;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      match_a[k] = hz.id_use_rs1 && (hz.id_rs1 != '0) && tbl_valid[k] &&
                   tbl_we[k] && (tbl_rd[k] == hz.id_rs1);
      match_b[k] = hz.id_use_rs2 && (hz.id_rs2 != '0) && tbl_valid[k] &&
                   tbl_we[k] && (tbl_rd[k] == hz.id_rs2);
    end
  end

  assign load_use = (match_a[0] | match_b[0]) & tbl_load[0];

`ifdef HZD_FORWARD_EN
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    // Walk from the oldest stage down so the youngest producer wins.
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (match_a[k]) sel_a = SW'(k + 1);
      if (match_b[k]) sel_b = SW'(k + 1);
    end
  end
  assign tbl_stall = load_use;
`else
  assign sel_a     = '0;
  assign sel_b     = '0;
  assign tbl_stall = load_use | (|match_a) | (|match_b);
`endif

  assign mc_stall = (state == S_BUSY) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 != '0) && (hz.id_rs1 == mc_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 != '0) && (hz.id_rs2 == mc_rd)) ||
                     (hz.id_reg_we && (hz.id_rd == mc_rd)) ||
                     hz.id_is_mc);

  assign hz_stall   = hz.id_valid & (tbl_stall | mc_stall);
  assign stall_int  = hz_stall & ~hz.flush;
  assign accept_any = hz.id_valid & ~hz_stall & ~hz.flush;
  assign accept     = accept_any & ~hz.id_is_mc;
  assign mc_start   = accept_any & hz.id_is_mc;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mc_rd_nxt = mc_rd;
    mc_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mc_start) begin
          state_nxt = S_BUSY;
          count_nxt = CW'(MC_LAT - 1);
          mc_rd_nxt = hz.id_rd;
        end
      end
      S_BUSY: begin
        if (count == '0) begin
          mc_done   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      mc_rd     <= '0;
      tbl_valid <= '0;
      tbl_we    <= '0;
      tbl_load  <= '0;
      tbl_rd    <= '0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      mc_rd        <= mc_rd_nxt;
      tbl_valid[0] <= accept;
      tbl_we[0]    <= hz.id_reg_we;
      tbl_load[0]  <= hz.id_is_load;
      tbl_rd[0]    <= hz.id_rd;
      for (int k = 1; k < FWD_STAGES; k++) begin
        tbl_valid[k] <= tbl_valid[k-1];
        tbl_we[k]    <= tbl_we[k-1];
        tbl_load[k]  <= tbl_load[k-1];
        tbl_rd[k]    <= tbl_rd[k-1];
      end
    end
  end

  // Outputs stay quiet while reset is held, even before the first sampling edge.
  assign hz.stall     = rst_n & stall_int;
  assign hz.bubble    = rst_n & (stall_int | hz.flush);
  assign hz.fwd_a_sel = rst_n ? sel_a : '0;
  assign hz.fwd_b_sel = rst_n ? sel_b : '0;
  assign hz.mc_busy   = rst_n & (state == S_BUSY);
  assign hz.mc_wb     = rst_n & mc_done;
  assign hz.mc_wb_rd  = hz.mc_wb ? mc_rd : '0;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-scenario stimulus tables with
// expected outputs queued at drive time and popped at the following negedge.
module tb_hazard_scoreboard;
  localparam int REG_AW     = 5;
  localparam int FWD_STAGES = 2;
  localparam int MC_LAT     = 4;
  localparam int SW         = $clog2(FWD_STAGES + 1);

  typedef struct packed {
    logic       rstn;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mc;
    logic       fl;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic       wb;
    logic [4:0] wbrd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .SW(SW)) hz ();

  hazard_scoreboard #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .MC_LAT    (MC_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  function automatic stim_t op(bit v, int rs1, bit u1, int rs2, bit u2, int rd,
                               bit we, bit ld, bit mc, bit fl, bit rstn);
    stim_t s;
    s.rstn = rstn; s.v = v; s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
    s.rd = 5'(rd); s.we = we; s.ld = ld; s.mc = mc; s.fl = fl;
    return s;
  endfunction

  function automatic stim_t alu(int rd, int rs1, int rs2);
    return op(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 0, 1);
  endfunction

  function automatic stim_t lw(int rd, int rs1);
    return op(1, rs1, 1, 0, 0, rd, 1, 1, 0, 0, 1);
  endfunction

  function automatic stim_t mul(int rd, int rs1, int rs2);
    return op(1, rs1, 1, rs2, 1, rd, 1, 0, 1, 0, 1);
  endfunction

  function automatic stim_t nop();
    return op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic stim_t with_flush(stim_t s);
    stim_t r = s;
    r.fl = 1'b1;
    return r;
  endfunction

  function automatic stim_t in_reset(stim_t s);
    stim_t r = s;
    r.rstn = 1'b0;
    return r;
  endfunction

  function automatic exp_t ex(bit st, bit bu, int fa, int fb, bit busy, bit wb, int wbrd);
    exp_t e;
    e.stall = st; e.bubble = bu; e.fa = 2'(fa); e.fb = 2'(fb);
    e.busy = busy; e.wb = wb; e.wbrd = 5'(wbrd);
    return e;
  endfunction

  task automatic apply(stim_t s);
    @(posedge clk);
    #1;
    rst_n         = s.rstn;
    hz.id_valid   = s.v;
    hz.id_rs1     = s.rs1;
    hz.id_use_rs1 = s.u1;
    hz.id_rs2     = s.rs2;
    hz.id_use_rs2 = s.u2;
    hz.id_rd      = s.rd;
    hz.id_reg_we  = s.we;
    hz.id_is_load = s.ld;
    hz.id_is_mc   = s.mc;
    hz.flush      = s.fl;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(in_reset(alu(5, 1, 2)));  e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(in_reset(alu(5, 1, 2)));  e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(alu(6, 5, 5));            e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());                   e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());                   e.push_back(ex(0,0,0,0,0,0,0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {hz.stall, hz.bubble, hz.fwd_a_sel, hz.fwd_b_sel, hz.mc_busy, hz.mc_wb, hz.mc_wb_rd};
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset step %0d: got %b required %b (stall,bubble,fa,fb,busy,wb,wbrd)", i, got, want);
      end
    end
  endtask

  task automatic test_alu_fwd();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(alu(5, 1, 2));  e.push_back(ex(0,0,0,0,0,0,0));
`ifdef HZD_FORWARD_EN
    s.push_back(alu(6, 5, 1));  e.push_back(ex(0,0,1,0,0,0,0));
    s.push_back(alu(7, 5, 3));  e.push_back(ex(0,0,2,0,0,0,0));
`else
    s.push_back(alu(6, 5, 1));  e.push_back(ex(1,1,0,0,0,0,0));
    s.push_back(alu(6, 5, 1));  e.push_back(ex(1,1,0,0,0,0,0));
    s.push_back(alu(6, 5, 1));  e.push_back(ex(0,0,0,0,0,0,0));
`endif
    s.push_back(alu(0, 1, 1));  e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(alu(9, 0, 0));  e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(alu(5, 1, 2));  e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(alu(5, 1, 2));  e.push_back(ex(0,0,0,0,0,0,0));
`ifdef HZD_FORWARD_EN
    s.push_back(alu(3, 5, 5));  e.push_back(ex(0,0,1,1,0,0,0));
`else
    s.push_back(alu(3, 5, 5));  e.push_back(ex(1,1,0,0,0,0,0));
`endif
    s.push_back(nop());         e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());         e.push_back(ex(0,0,0,0,0,0,0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {hz.stall, hz.bubble, hz.fwd_a_sel, hz.fwd_b_sel, hz.mc_busy, hz.mc_wb, hz.mc_wb_rd};
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL alu_fwd step %0d: got %b required %b (stall,bubble,fa,fb,busy,wb,wbrd)", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(lw(7, 1));      e.push_back(ex(0,0,0,0,0,0,0));
`ifdef HZD_FORWARD_EN
    s.push_back(alu(8, 7, 7));  e.push_back(ex(1,1,1,1,0,0,0));
    s.push_back(alu(8, 7, 7));  e.push_back(ex(0,0,2,2,0,0,0));
`else
    s.push_back(alu(8, 7, 7));  e.push_back(ex(1,1,0,0,0,0,0));
    s.push_back(alu(8, 7, 7));  e.push_back(ex(1,1,0,0,0,0,0));
    s.push_back(alu(8, 7, 7));  e.push_back(ex(0,0,0,0,0,0,0));
`endif
    s.push_back(nop());         e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());         e.push_back(ex(0,0,0,0,0,0,0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {hz.stall, hz.bubble, hz.fwd_a_sel, hz.fwd_b_sel, hz.mc_busy, hz.mc_wb, hz.mc_wb_rd};
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL load_use step %0d: got %b required %b (stall,bubble,fa,fb,busy,wb,wbrd)", i, got, want);
      end
    end
  endtask

  task automatic test_multicycle();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    // mul x9 accepted at the edge after step 0: busy steps 1..4, write-back at step 4
    s.push_back(mul(9, 1, 2));    e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(alu(10, 9, 1));   e.push_back(ex(1,1,0,0,1,0,0));
    s.push_back(alu(10, 9, 1));   e.push_back(ex(1,1,0,0,1,0,0));
    s.push_back(alu(10, 9, 1));   e.push_back(ex(1,1,0,0,1,0,0));
    s.push_back(alu(10, 9, 1));   e.push_back(ex(1,1,0,0,1,1,9));
    s.push_back(alu(10, 9, 1));   e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(mul(9, 3, 4));    e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(mul(12, 3, 4));   e.push_back(ex(1,1,0,0,1,0,0));
    s.push_back(alu(9, 1, 2));    e.push_back(ex(1,1,0,0,1,0,0));
    s.push_back(alu(13, 1, 2));   e.push_back(ex(0,0,0,0,1,0,0));
    s.push_back(nop());           e.push_back(ex(0,0,0,0,1,1,9));
    s.push_back(nop());           e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());           e.push_back(ex(0,0,0,0,0,0,0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {hz.stall, hz.bubble, hz.fwd_a_sel, hz.fwd_b_sel, hz.mc_busy, hz.mc_wb, hz.mc_wb_rd};
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL multicycle step %0d: got %b required %b (stall,bubble,fa,fb,busy,wb,wbrd)", i, got, want);
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(lw(7, 1));                    e.push_back(ex(0,0,0,0,0,0,0));
`ifdef HZD_FORWARD_EN
    s.push_back(with_flush(alu(11, 7, 1)));   e.push_back(ex(0,1,1,0,0,0,0));
`else
    s.push_back(with_flush(alu(11, 7, 1)));   e.push_back(ex(0,1,0,0,0,0,0));
`endif
    s.push_back(alu(12, 11, 11));             e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(alu(13, 11, 11));             e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(mul(9, 1, 2));                e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(with_flush(alu(14, 9, 1)));   e.push_back(ex(0,1,0,0,1,0,0));
    s.push_back(nop());                       e.push_back(ex(0,0,0,0,1,0,0));
    s.push_back(nop());                       e.push_back(ex(0,0,0,0,1,0,0));
    s.push_back(nop());                       e.push_back(ex(0,0,0,0,1,1,9));
    s.push_back(nop());                       e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());                       e.push_back(ex(0,0,0,0,0,0,0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {hz.stall, hz.bubble, hz.fwd_a_sel, hz.fwd_b_sel, hz.mc_busy, hz.mc_wb, hz.mc_wb_rd};
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL flush step %0d: got %b required %b (stall,bubble,fa,fb,busy,wb,wbrd)", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(mul(9, 1, 2));        e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());               e.push_back(ex(0,0,0,0,1,0,0));
    s.push_back(in_reset(nop()));     e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(alu(10, 9, 1));       e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());               e.push_back(ex(0,0,0,0,0,0,0));
    s.push_back(nop());               e.push_back(ex(0,0,0,0,0,0,0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      got  = {hz.stall, hz.bubble, hz.fwd_a_sel, hz.fwd_b_sel, hz.mc_busy, hz.mc_wb, hz.mc_wb_rd};
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_busy step %0d: got %b required %b (stall,bubble,fa,fb,busy,wb,wbrd)", i, got, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hz.id_valid   = 1'b0;
    hz.id_rs1     = '0;
    hz.id_rs2     = '0;
    hz.id_use_rs1 = 1'b0;
    hz.id_use_rs2 = 1'b0;
    hz.id_rd      = '0;
    hz.id_reg_we  = 1'b0;
    hz.id_is_load = 1'b0;
    hz.id_is_mc   = 1'b0;
    hz.flush      = 1'b0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_multicycle();
    test_flush();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
